// File: rtl/dz_modem_filter_pkg.sv
// Purpose: shared types and line-layout constants for the DZ11 modem-control filter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: dzModem_t is the 16-bit {CO[7:0],RI[7:0]} vector.
// DZ_CO_LSB/DZ_RI_LSB locate each field inside that vector.
package dz_modem_pkg;

  typedef logic [15:0] dzModem_t;

  localparam int DZ_CO_LSB = 8;
  localparam int DZ_RI_LSB = 0;
  localparam int DZ_LINES  = 8;

endpackage

// File: rtl/dz_modem_filter_if.sv
// Purpose: bundles the raw modem pins and the conditioned MSR-side levels.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level, sampled by the receiver each clock.
// Ports: rawCO/rawRI are pins into the filter.
// dzCO/dzRI/dzCHG/dzCHGMSK come out of the filter.
// master = pin/MSR side, slave = filter.
interface dz_modem_if;
  import dz_modem_pkg::*;

  logic [DZ_LINES-1:0] rawCO;
  logic [DZ_LINES-1:0] rawRI;
  logic [DZ_LINES-1:0] dzCO;
  logic [DZ_LINES-1:0] dzRI;
  logic                dzCHG;
  dzModem_t            dzCHGMSK;

  modport master (
    output rawCO, rawRI,
    input  dzCO, dzRI, dzCHG, dzCHGMSK
  );

  modport slave (
    input  rawCO, rawRI,
    output dzCO, dzRI, dzCHG, dzCHGMSK
  );

endinterface

// File: rtl/dz_modem_filter_debounce.sv
// Purpose: one modem-control bit.
//   It has a 2-flop synchroniser, a tick-driven debounce counter and a registered output level.
// Latency: 2 clocks sync + DEBOUNCE ticks (the first tick may be partial).
// Backpressure: none; out_o is a level.
// Ports: clk, rst (sync, active-high), tick_i (shared prescaler tick), raw_i (async pin).
//   out_o is the clean level.
//   upd_o is high in the cycle whose edge flips out_o.
module dz_debounce_bit #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic out_o,
  output logic upd_o
);

  localparam int DCW = $clog2(DEBOUNCE + 1);

  logic           meta_q;
  logic           syn_q;
  logic           out_q, out_d;
  logic [DCW-1:0] dc_q, dc_d;

  // Any clock where the synchronised level agrees with the output clears
  // the count, so a level must disagree across DEBOUNCE consecutive ticks.
  always_comb begin
    out_d = out_q;
    dc_d  = dc_q;
    upd_o = 1'b0;
    if (syn_q == out_q) begin
      dc_d = '0;
    end else if (tick_i) begin
      if (dc_q == DCW'(DEBOUNCE - 1)) begin
        out_d = syn_q;
        dc_d  = '0;
        upd_o = 1'b1;
      end else begin
        dc_d = dc_q + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      syn_q  <= 1'b0;
      out_q  <= 1'b0;
      dc_q   <= '0;
    end else begin
      meta_q <= raw_i;
      syn_q  <= meta_q;
      out_q  <= out_d;
      dc_q   <= dc_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/dz_modem_filter.sv
// Purpose: conditions 8 lines of DZ11 carrier-detect / ring-indicator inputs for the MSR.
// Latency: between (DEBOUNCE-1)*PRESCALE+3 and DEBOUNCE*PRESCALE+2 clocks, pin to output.
// Backpressure: none; outputs are registered levels, sampled every clock.
// Ports: clk, rst (sync, active-high), bus (dz_modem_if.slave: rawCO/rawRI in;
//   dzCO/dzRI/dzCHG/dzCHGMSK out).
// Optional feature: define DZ_MODEM_CHANGE_EN for the dzCHG strobe and the dzCHGMSK register.
//   When it is undefined, both are tied to zero.
module dz_modem_filter
  import dz_modem_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int DEBOUNCE = 8
) (
  input  logic      clk,
  input  logic      rst,
  dz_modem_if.slave bus
);

  localparam int CNTW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tick;
  dzModem_t        raw_vec;
  dzModem_t        out_vec;
  dzModem_t        upd_vec;

  // Shared prescaler. One tick per PRESCALE clocks drives all 16 bits,
  // so bits that qualify together update on the same edge.
  assign tick  = (cnt_q == CNTW'(PRESCALE - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNTW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign raw_vec = {bus.rawCO, bus.rawRI};

  for (genvar i = 0; i < 16; i++) begin : g_bit
    dz_debounce_bit #(
      .DEBOUNCE(DEBOUNCE)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .tick_i(tick),
      .raw_i (raw_vec[i]),
      .out_o (out_vec[i]),
      .upd_o (upd_vec[i])
    );
  end

  assign bus.dzCO = out_vec[DZ_CO_LSB +: DZ_LINES];
  assign bus.dzRI = out_vec[DZ_RI_LSB +: DZ_LINES];

`ifdef DZ_MODEM_CHANGE_EN
  logic     chg_q;
  dzModem_t msk_q;

  // An update always flips its bit, so upd_vec already equals old^new.
  // Registering upd_vec on the same edge as the outputs makes the strobe
  // and mask line up with the new output levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q <= 1'b0;
      msk_q <= '0;
    end else begin
      chg_q <= |upd_vec;
      if (|upd_vec) begin
        msk_q <= upd_vec;
      end
    end
  end

  assign bus.dzCHG    = chg_q;
  assign bus.dzCHGMSK = msk_q;
`else
  logic unused_upd;
  assign unused_upd   = ^upd_vec;
  assign bus.dzCHG    = 1'b0;
  assign bus.dzCHGMSK = '0;
`endif

endmodule

// File: tb/tb_dz_modem_filter.sv
// Purpose: self-checking bench for dz_modem_filter with PRESCALE=4 and DEBOUNCE=3.
// Latency: n/a.
// Backpressure: n/a.
// Ports: none. The bench instantiates dz_modem_if and the DUT.
//   Change-strobe expectations follow DZ_MODEM_CHANGE_EN.
module tb_dz_modem_filter;
  import dz_modem_pkg::*;

  localparam int P = 4;
  localparam int D = 3;
`ifdef DZ_MODEM_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dz_modem_if bus ();

  dz_modem_filter #(.PRESCALE(P), .DEBOUNCE(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Reference model.
  // A level reaches the output once it has been seen as different from the output at DEBOUNCE
  // consecutive ticks, after two clocks of synchroniser delay.
  // Ticks fall on every PRESCALE-th clock after reset.
  dzModem_t m_s1, m_s2, m_out, m_msk;
  logic     m_chg;
  int       m_run[16];
  int       m_cyc;

  function automatic void model_edge(logic r, dzModem_t raw);
    dzModem_t flips;
    bit tk;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_msk = '0; m_chg = 1'b0; m_cyc = 0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
    end else begin
      tk = ((m_cyc % P) == P - 1);
      flips = '0;
      for (int i = 0; i < 16; i++) begin
        if (m_s2[i] == m_out[i]) m_run[i] = 0;
        else if (tk) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            flips[i] = 1'b1;
            m_run[i] = 0;
          end
        end
      end
      m_out = m_out ^ flips;
      if (CHG_EN) begin
        m_chg = |flips;
        if (|flips) m_msk = flips;
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_cyc++;
    end
  endfunction

  task automatic step();
    logic     r;
    dzModem_t raw;
    @(posedge clk);
    r   = rst;
    raw = {bus.rawCO, bus.rawRI};
    model_edge(r, raw);
    #1;
    check("model_out", {bus.dzCO, bus.dzRI}, m_out);
    check("model_chg", 16'(bus.dzCHG), 16'(m_chg));
    check("model_msk", bus.dzCHGMSK, m_msk);
  endtask

  task automatic drive(logic [7:0] co, logic [7:0] ri);
    bus.rawCO = co;
    bus.rawRI = ri;
  endtask

  typedef struct {
    logic [7:0] co;
    logic [7:0] ri;
    logic [7:0] eco;
    logic [7:0] eri;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int  n;
    int  pulses;
    bit  found;
    bit  bad;

    tbl[0] = '{co: 8'h00, ri: 8'h00, eco: 8'h00, eri: 8'h00};
    tbl[1] = '{co: 8'h04, ri: 8'h00, eco: 8'h04, eri: 8'h00};
    tbl[2] = '{co: 8'h04, ri: 8'h20, eco: 8'h04, eri: 8'h20};
    tbl[3] = '{co: 8'h81, ri: 8'h01, eco: 8'h81, eri: 8'h01};
    tbl[4] = '{co: 8'hFF, ri: 8'hFF, eco: 8'hFF, eri: 8'hFF};
    tbl[5] = '{co: 8'h5A, ri: 8'hA5, eco: 8'h5A, eri: 8'hA5};
    tbl[6] = '{co: 8'h00, ri: 8'h00, eco: 8'h00, eri: 8'h00};

    // 1. Reset with all pins high, then two quiet clocks after release.
    drive(8'hFF, 8'hFF);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_rst_co", {8'h00, bus.dzCO}, 16'h0000);
      check("t1_rst_ri", {8'h00, bus.dzRI}, 16'h0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("t1_rel_co", {8'h00, bus.dzCO}, 16'h0000);
      check("t1_rel_ri", {8'h00, bus.dzRI}, 16'h0000);
    end
    drive(8'h00, 8'h00);
    repeat (20) step();

    // Table: hold each pattern long enough to settle, then compare.
    for (int v = 0; v < 7; v++) begin
      drive(tbl[v].co, tbl[v].ri);
      repeat (18) step();
      check($sformatf("tbl%0d_co", v), {8'h00, bus.dzCO}, {8'h00, tbl[v].eco});
      check($sformatf("tbl%0d_ri", v), {8'h00, bus.dzRI}, {8'h00, tbl[v].eri});
    end

    // 2. Latency window for a single CO bit.
    drive(8'h04, 8'h00);
    n = 0;
    bad = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (bus.dzRI != 8'h00) bad = 1'b1;
      if (bus.dzCO == 8'h04) begin
        n = k;
        break;
      end
    end
    check("t2_latency_ge11", 16'(n >= 11), 16'h0001);
    check("t2_latency_le14", 16'(n <= 14), 16'h0001);
    check("t2_ri_quiet", 16'(bad), 16'h0000);
    drive(8'h00, 8'h00);
    repeat (20) step();

    // 3. Six-clock RI glitch must be rejected.
    drive(8'h00, 8'h20);
    repeat (6) step();
    drive(8'h00, 8'h00);
    bad = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.dzRI != 8'h00) bad = 1'b1;
      if (bus.dzCHG) pulses++;
    end
    check("t3_ri_stays_0", 16'(bad), 16'h0000);
    check("t3_no_chg", 16'(pulses), 16'h0000);

    // 4. Three bits qualifying together update on one edge.
    drive(8'h81, 8'h01);
    found = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.dzCHG) pulses++;
      if (!found && (bus.dzCO != 8'h00 || bus.dzRI != 8'h00)) begin
        found = 1'b1;
        check("t4_co", {8'h00, bus.dzCO}, 16'h0081);
        check("t4_ri", {8'h00, bus.dzRI}, 16'h0001);
        check("t4_chg", 16'(bus.dzCHG), 16'(CHG_EN));
        check("t4_msk", bus.dzCHGMSK, CHG_EN ? 16'h8101 : 16'h0000);
      end
    end
    check("t4_found", 16'(found), 16'h0001);
    check("t4_pulses", 16'(pulses), 16'(CHG_EN));
    check("t4_msk_held", bus.dzCHGMSK, CHG_EN ? 16'h8101 : 16'h0000);

    // 5. Reset after two ticks discards the partial count.
    drive(8'h00, 8'h00);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    drive(8'h01, 8'h00);
    bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.dzCO[0]) bad = 1'b1;
    end
    rst = 1'b1;
    step();
    if (bus.dzCO[0]) bad = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (bus.dzCO[0]) bad = 1'b1;
    end
    check("t5_held_low", 16'(bad), 16'h0000);
    step();
    check("t5_rises_at_12", {8'h00, bus.dzCO}, 16'h0001);

    // Random levels and glitches, checked against the model every clock.
    for (int s = 0; s < 60; s++) begin
      drive(8'($urandom), 8'($urandom));
      n = $urandom_range(1, 14);
      repeat (n) step();
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
